// File: rtl/vga_timing_pkg.sv
// Shared raster timing constants for the VGA path: 640x480@60 defaults,
// derived totals, sync window positions and a small window-test helper.
package vga_timing_pkg;

    // Coordinate and frame counter widths on the block boundary
    localparam int POS_W  = 10;
    localparam int FCNT_W = 8;

    typedef logic [POS_W-1:0]  pos_t;
    typedef logic [FCNT_W-1:0] fcnt_t;

    // 640x480@60 defaults
    localparam int DEF_H_VISIBLE = 640;
    localparam int DEF_H_FRONT   = 16;
    localparam int DEF_H_SYNC    = 96;
    localparam int DEF_H_BACK    = 48;
    localparam int DEF_V_VISIBLE = 480;
    localparam int DEF_V_FRONT   = 10;
    localparam int DEF_V_SYNC    = 2;
    localparam int DEF_V_BACK    = 33;

    // Derived totals (800 x 525 for the defaults)
    localparam int DEF_H_TOTAL = DEF_H_VISIBLE + DEF_H_FRONT + DEF_H_SYNC + DEF_H_BACK;
    localparam int DEF_V_TOTAL = DEF_V_VISIBLE + DEF_V_FRONT + DEF_V_SYNC + DEF_V_BACK;

    // Sync windows, inclusive (656..751 and 490..491 for the defaults)
    localparam int DEF_H_SYNC_START = DEF_H_VISIBLE + DEF_H_FRONT;
    localparam int DEF_H_SYNC_END   = DEF_H_SYNC_START + DEF_H_SYNC - 1;
    localparam int DEF_V_SYNC_START = DEF_V_VISIBLE + DEF_V_FRONT;
    localparam int DEF_V_SYNC_END   = DEF_V_SYNC_START + DEF_V_SYNC - 1;

    // True when p lies in the inclusive window [lo, hi]
    function automatic logic in_window(input pos_t p, input pos_t lo, input pos_t hi);
        return (p >= lo) && (p <= hi);
    endfunction

endpackage

// File: rtl/sync_delay_line.sv
// Single-bit shift register used to align the sync outputs with the
// registered video path. DEPTH of 0 is a plain passthrough; reset loads
// every stage with RESET_VAL so no partial pulse survives a reset.
module sync_delay_line #(
    parameter int   DEPTH     = 1,
    parameter logic RESET_VAL = 1'b0
) (
    input  logic i_clk,
    input  logic i_rst_n,
    input  logic i_d,
    output logic o_q
);

    generate
        if (DEPTH == 0) begin : g_pass
            assign o_q = i_d;
        end else begin : g_shift
            logic [DEPTH-1:0] r_sr;

            // Shift every clock; reset flushes all stages to the idle level
            always_ff @(posedge i_clk) begin
                if (!i_rst_n) begin
                    r_sr <= {DEPTH{RESET_VAL}};
                end else begin
                    r_sr[0] <= i_d;
                    for (int i = 1; i < DEPTH; i++) begin
                        r_sr[i] <= r_sr[i-1];
                    end
                end
            end

            assign o_q = r_sr[DEPTH-1];
        end
    endgenerate

endmodule

// File: rtl/vga_sync_generator.sv
// Raster timing source: free-running h/v counters with registered position,
// visible flag, line/frame strobes, frame counter, and hsync/vsync delayed
// to match the downstream video pipeline latency.
module vga_sync_generator
    import vga_timing_pkg::*;
#(
    parameter int H_VISIBLE       = DEF_H_VISIBLE,
    parameter int H_FRONT         = DEF_H_FRONT,
    parameter int H_SYNC          = DEF_H_SYNC,
    parameter int H_BACK          = DEF_H_BACK,
    parameter int V_VISIBLE       = DEF_V_VISIBLE,
    parameter int V_FRONT         = DEF_V_FRONT,
    parameter int V_SYNC          = DEF_V_SYNC,
    parameter int V_BACK          = DEF_V_BACK,
    parameter int SYNC_DELAY      = 1,
    parameter int SYNC_ACTIVE_LOW = 1
) (
    input  logic        i_clk,
    input  logic        i_rst_n,
    input  logic        i_enable,
    output logic [9:0]  o_hpos,
    output logic [9:0]  o_vpos,
    output logic        o_visible,
    output logic        o_line_strobe,
    output logic        o_frame_strobe,
    output logic [7:0]  o_frame_count,
    output logic        o_hsync,
    output logic        o_vsync
);

    localparam int H_TOTAL = H_VISIBLE + H_FRONT + H_SYNC + H_BACK;
    localparam int V_TOTAL = V_VISIBLE + V_FRONT + V_SYNC + V_BACK;

    localparam pos_t H_LAST   = pos_t'(H_TOTAL - 1);
    localparam pos_t V_LAST   = pos_t'(V_TOTAL - 1);
    localparam pos_t H_VIS    = pos_t'(H_VISIBLE);
    localparam pos_t V_VIS    = pos_t'(V_VISIBLE);
    localparam pos_t HS_START = pos_t'(H_VISIBLE + H_FRONT);
    localparam pos_t HS_END   = pos_t'(H_VISIBLE + H_FRONT + H_SYNC - 1);
    localparam pos_t VS_START = pos_t'(V_VISIBLE + V_FRONT);
    localparam pos_t VS_END   = pos_t'(V_VISIBLE + V_FRONT + V_SYNC - 1);

    localparam logic SYNC_IDLE = (SYNC_ACTIVE_LOW != 0);
    localparam logic SYNC_ACT  = (SYNC_ACTIVE_LOW == 0);

    pos_t  r_hpos;
    pos_t  r_vpos;
    logic  r_visible;
    logic  r_line_strobe;
    logic  r_frame_strobe;
    fcnt_t r_frame_count;
    logic  r_hsync_raw;
    logic  r_vsync_raw;

    pos_t  w_hpos_nxt;
    pos_t  w_vpos_nxt;
    logic  w_frame_hit;

    // Advanced raster position, used only on enabled cycles
    always_comb begin
        w_hpos_nxt = r_hpos + pos_t'(1);
        w_vpos_nxt = r_vpos;
        if (r_hpos == H_LAST) begin
            w_hpos_nxt = '0;
            w_vpos_nxt = (r_vpos == V_LAST) ? '0 : (r_vpos + pos_t'(1));
        end
        w_frame_hit = (w_hpos_nxt == '0) && (w_vpos_nxt == V_VIS);
    end

    // All flags derive from the next-state position so they stay consistent
    // with the registered coordinates; strobes drop whenever not advancing
    always_ff @(posedge i_clk) begin
        if (!i_rst_n) begin
            r_hpos         <= H_LAST;
            r_vpos         <= V_LAST;
            r_visible      <= 1'b0;
            r_line_strobe  <= 1'b0;
            r_frame_strobe <= 1'b0;
            r_frame_count  <= '0;
            r_hsync_raw    <= SYNC_IDLE;
            r_vsync_raw    <= SYNC_IDLE;
        end else if (i_enable) begin
            r_hpos         <= w_hpos_nxt;
            r_vpos         <= w_vpos_nxt;
            r_visible      <= (w_hpos_nxt < H_VIS) && (w_vpos_nxt < V_VIS);
            r_line_strobe  <= (w_hpos_nxt == '0);
            r_frame_strobe <= w_frame_hit;
            if (w_frame_hit) begin
                r_frame_count <= r_frame_count + fcnt_t'(1);
            end
            r_hsync_raw    <= in_window(w_hpos_nxt, HS_START, HS_END) ? SYNC_ACT : SYNC_IDLE;
            r_vsync_raw    <= in_window(w_vpos_nxt, VS_START, VS_END) ? SYNC_ACT : SYNC_IDLE;
        end else begin
            r_line_strobe  <= 1'b0;
            r_frame_strobe <= 1'b0;
        end
    end

    sync_delay_line #(
        .DEPTH     (SYNC_DELAY),
        .RESET_VAL (SYNC_IDLE)
    ) u_hsync_dly (
        .i_clk   (i_clk),
        .i_rst_n (i_rst_n),
        .i_d     (r_hsync_raw),
        .o_q     (o_hsync)
    );

    sync_delay_line #(
        .DEPTH     (SYNC_DELAY),
        .RESET_VAL (SYNC_IDLE)
    ) u_vsync_dly (
        .i_clk   (i_clk),
        .i_rst_n (i_rst_n),
        .i_d     (r_vsync_raw),
        .o_q     (o_vsync)
    );

    assign o_hpos         = r_hpos;
    assign o_vpos         = r_vpos;
    assign o_visible      = r_visible;
    assign o_line_strobe  = r_line_strobe;
    assign o_frame_strobe = r_frame_strobe;
    assign o_frame_count  = r_frame_count;

endmodule

// File: tb/tb_vga_sync_generator.sv
// Bench for vga_sync_generator using a shrunken raster (25 x 19) so whole
// frames fit in a short run. The reference model derives everything from
// the count of enabled cycles since reset plus a short history of raw syncs.
module tb_vga_sync_generator;

    localparam int HV = 16, HF = 2, HS = 4, HB = 3;
    localparam int VV = 12, VF = 2, VS = 2, VB = 3;
    localparam int SD = 1;
    localparam int HT = HV + HF + HS + HB;  // 25
    localparam int VT = VV + VF + VS + VB;  // 19
    localparam int FT = HT * VT;            // 475
    localparam int HS_LO = HV + HF, HS_HI = HV + HF + HS - 1;  // 18..21
    localparam int VS_LO = VV + VF, VS_HI = VV + VF + VS - 1;  // 14..15
    localparam logic IDLE = 1'b1;
    localparam logic ACT  = 1'b0;

    logic       i_clk;
    logic       i_rst_n;
    logic       i_enable;
    logic [9:0] o_hpos;
    logic [9:0] o_vpos;
    logic       o_visible;
    logic       o_line_strobe;
    logic       o_frame_strobe;
    logic [7:0] o_frame_count;
    logic       o_hsync;
    logic       o_vsync;

    vga_sync_generator #(
        .H_VISIBLE(HV), .H_FRONT(HF), .H_SYNC(HS), .H_BACK(HB),
        .V_VISIBLE(VV), .V_FRONT(VF), .V_SYNC(VS), .V_BACK(VB),
        .SYNC_DELAY(SD), .SYNC_ACTIVE_LOW(1)
    ) dut (
        .i_clk          (i_clk),
        .i_rst_n        (i_rst_n),
        .i_enable       (i_enable),
        .o_hpos         (o_hpos),
        .o_vpos         (o_vpos),
        .o_visible      (o_visible),
        .o_line_strobe  (o_line_strobe),
        .o_frame_strobe (o_frame_strobe),
        .o_frame_count  (o_frame_count),
        .o_hsync        (o_hsync),
        .o_vsync        (o_vsync)
    );

    initial i_clk = 1'b0;
    always #5 i_clk = ~i_clk;

    int   errors = 0;
    int   checks = 0;

    // Reference model state
    bit   mvalid = 0;
    int   n_en   = 0;
    bit   adv    = 0;
    logic hh [8];
    logic vh [8];
    int   eh, ev, efc;
    bit   evis, els, efs;

    task automatic chk(input string name, input int act, input int exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d (t=%0t)", name, act, exp, $time);
        end
    endtask

    task automatic model_step(input logic r, input logic e);
        int p;
        if (!r) begin
            mvalid = 1;
            n_en   = 0;
            adv    = 0;
            for (int k = 0; k < 8; k++) begin
                hh[k] = IDLE;
                vh[k] = IDLE;
            end
        end else begin
            adv = e;
            if (e) n_en++;
        end
        if (n_en == 0) begin
            eh = HT - 1;
            ev = VT - 1;
        end else begin
            p  = (n_en - 1) % FT;
            eh = p % HT;
            ev = p / HT;
        end
        evis = (eh < HV) && (ev < VV);
        els  = adv && (eh == 0);
        efs  = els && (ev == VV);
        efc  = (n_en >= 1 + VV * HT) ? (((n_en - 1 - VV * HT) / FT) + 1) % 256 : 0;
        if (r) begin
            for (int k = 7; k > 0; k--) begin
                hh[k] = hh[k-1];
                vh[k] = vh[k-1];
            end
            hh[0] = (eh >= HS_LO && eh <= HS_HI) ? ACT : IDLE;
            vh[0] = (ev >= VS_LO && ev <= VS_HI) ? ACT : IDLE;
        end
    endtask

    task automatic compare_all();
        chk("hpos",         int'(o_hpos),         eh);
        chk("vpos",         int'(o_vpos),         ev);
        chk("visible",      int'(o_visible),      int'(evis));
        chk("line_strobe",  int'(o_line_strobe),  int'(els));
        chk("frame_strobe", int'(o_frame_strobe), int'(efs));
        chk("frame_count",  int'(o_frame_count),  efc);
        chk("hsync",        int'(o_hsync),        int'(hh[SD]));
        chk("vsync",        int'(o_vsync),        int'(vh[SD]));
    endtask

    // One clock: drive inputs, advance model at the edge, compare after it
    task automatic tick(input logic r, input logic e);
        i_rst_n  = r;
        i_enable = e;
        @(posedge i_clk);
        model_step(r, e);
        #1;
        if (mvalid) compare_all();
    endtask

    task automatic run_to(input int h, input int v, input string name);
        int k = 0;
        while (!(eh == h && ev == v) && k < 2 * FT) begin
            tick(1'b1, 1'b1);
            k++;
        end
        checks++;
        if (!(eh == h && ev == v)) begin
            errors++;
            $display("FAIL %s: position not reached, got (%0d,%0d) expected (%0d,%0d)", name, eh, ev, h, v);
        end
    endtask

    int n_ls, n_fs, n_low;

    initial begin
        i_rst_n  = 1'b0;
        i_enable = 1'b0;

        // Reset state, including reset overriding enable
        tick(1'b0, 1'b0);
        tick(1'b0, 1'b1);
        tick(1'b0, 1'b1);
        chk("rst_hpos",  int'(o_hpos), 24);
        chk("rst_vpos",  int'(o_vpos), 18);
        chk("rst_vis",   int'(o_visible), 0);
        chk("rst_fc",    int'(o_frame_count), 0);
        chk("rst_ls",    int'(o_line_strobe), 0);
        chk("rst_hsync", int'(o_hsync), 1);
        chk("rst_vsync", int'(o_vsync), 1);

        // First enabled cycle presents (0,0) visible with a line strobe
        tick(1'b1, 1'b1);
        chk("first_hpos", int'(o_hpos), 0);
        chk("first_vpos", int'(o_vpos), 0);
        chk("first_vis",  int'(o_visible), 1);
        chk("first_ls",   int'(o_line_strobe), 1);

        // Visible edge: last visible column, then first blank column
        repeat (15) tick(1'b1, 1'b1);
        chk("edge_hpos15", int'(o_hpos), 15);
        chk("edge_vis15",  int'(o_visible), 1);
        tick(1'b1, 1'b1);
        chk("edge_hpos16", int'(o_hpos), 16);
        chk("edge_vis16",  int'(o_visible), 0);
        chk("edge_ls16",   int'(o_line_strobe), 0);

        // Hsync lags the raw window by one clock and lasts four clocks
        run_to(18, 0, "reach_hsync");
        chk("hs_at18", int'(o_hsync), 1);
        tick(1'b1, 1'b1);
        chk("hs_at19", int'(o_hsync), 0);
        n_low = 1;
        for (int k = 0; k < HT - 1; k++) begin
            tick(1'b1, 1'b1);
            if (o_hsync == 1'b0) n_low++;
        end
        chk("hs_width", n_low, 4);

        // Freeze mid-line: position holds, no strobes, then resumes
        run_to(5, 3, "reach_freeze");
        repeat (6) tick(1'b1, 1'b0);
        chk("frz_hpos", int'(o_hpos), 5);
        chk("frz_vpos", int'(o_vpos), 3);
        chk("frz_ls",   int'(o_line_strobe), 0);
        tick(1'b1, 1'b1);
        chk("frz_resume", int'(o_hpos), 6);

        // Hold at the frame strobe position: a single strobe, single increment
        run_to(24, 11, "reach_pre_frame");
        tick(1'b1, 1'b1);
        chk("fs_hpos", int'(o_hpos), 0);
        chk("fs_vpos", int'(o_vpos), 12);
        chk("fs_pulse", int'(o_frame_strobe), 1);
        chk("fs_fc",   int'(o_frame_count), 1);
        repeat (4) tick(1'b1, 1'b0);
        chk("fs_hold_pulse", int'(o_frame_strobe), 0);
        chk("fs_hold_fc",    int'(o_frame_count), 1);
        tick(1'b1, 1'b1);
        chk("fs_resume_h",  int'(o_hpos), 1);
        chk("fs_resume_fs", int'(o_frame_strobe), 0);
        chk("fs_resume_fc", int'(o_frame_count), 1);

        // One full frame of enabled clocks
        n_ls = 0;
        n_fs = 0;
        for (int k = 0; k < FT; k++) begin
            tick(1'b1, 1'b1);
            if (o_line_strobe)  n_ls++;
            if (o_frame_strobe) n_fs++;
        end
        chk("frame_ls_count", n_ls, 19);
        chk("frame_fs_count", n_fs, 1);
        chk("frame_wrap_h",   int'(o_hpos), 1);
        chk("frame_wrap_v",   int'(o_vpos), 12);
        chk("frame_fc",       int'(o_frame_count), 2);

        // Vsync lags its raw line window by one clock
        run_to(0, 14, "reach_vsync");
        chk("vs_at_start", int'(o_vsync), 1);
        tick(1'b1, 1'b1);
        chk("vs_after", int'(o_vsync), 0);

        // Randomised enable gaps with occasional resets
        for (int k = 0; k < 3000; k++) begin
            tick(logic'($urandom_range(0, 299) != 0), logic'($urandom_range(0, 7) != 0));
        end

        // Reset during active hsync and vsync flushes the sync pipeline
        tick(1'b1, 1'b1);
        run_to(19, 14, "reach_sync_region");
        chk("mid_hsync", int'(o_hsync), 0);
        chk("mid_vsync", int'(o_vsync), 0);
        tick(1'b0, 1'b1);
        chk("mrst_hpos",  int'(o_hpos), 24);
        chk("mrst_vpos",  int'(o_vpos), 18);
        chk("mrst_fc",    int'(o_frame_count), 0);
        chk("mrst_hsync", int'(o_hsync), 1);
        chk("mrst_vsync", int'(o_vsync), 1);
        chk("mrst_vis",   int'(o_visible), 0);
        tick(1'b1, 1'b1);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
